// File: rtl/i2c_slave_mem_param_if.sv
// I2C pin pair plus the host-side read port and write strobe of the register-file target.
interface i2c_slave_mem_param_if #(
    parameter int AW = 8
);
    logic          scl_i;
    logic          sda_i;
    logic          sda_oe;
    logic          bus_busy;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_rdata;
    logic          wr_strobe;

    modport slave (
        input  scl_i, sda_i, host_addr,
        output sda_oe, bus_busy, host_rdata, wr_strobe
    );

    modport master (
        output scl_i, sda_i, host_addr,
        input  sda_oe, bus_busy, host_rdata, wr_strobe
    );
endinterface

// File: rtl/i2c_slave_mem_param.sv
// I2C target with a DEPTH x 8 register file, 1/2-byte auto-incrementing pointer and host read port.
// Bus events act 3 clk after the pin changes; no clock stretching, host_rdata is a 1-cycle registered read.
module i2c_slave_mem_param #(
    parameter int DEPTH     = 256,
    parameter int PTR_BYTES = 1,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            id,
    input  logic                  wp,
    i2c_slave_mem_param_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    localparam logic LAST_PB = 1'(PTR_BYTES - 1);

    state_t        state;
    logic          scl_s1, scl_s2, scl_d;
    logic          sda_s1, sda_s2, sda_d;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic [7:0]    ptr_hi;
    logic          pcnt;
    logic          ptr_done;
    logic          phase;
    logic          rw;
    logic [AW-1:0] ptr;
    logic [7:0]    mem [DEPTH];

    logic          scl_rise, scl_fall, start_det, stop_det, byte_done, mem_we;
    logic [7:0]    rx_byte, rd_byte;
    logic [15:0]   ptr_full;
    logic [AW-1:0] ptr_new;

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign rx_byte   = {shreg[6:0], sda_s2};
    assign byte_done = scl_rise & (bitcnt == 3'd7);
    assign rd_byte   = mem[ptr];
    assign ptr_full  = (PTR_BYTES == 2) ? {ptr_hi, rx_byte} : {8'h00, rx_byte};
    assign ptr_new   = AW'(ptr_full);
    // START/STOP win over a byte completing in the same cycle, so the byte is dropped
    assign mem_we    = rst_n & ~start_det & ~stop_det & (state == WDATA) & byte_done & ~wp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d} <= 6'b111111;
        end else begin
            scl_s1 <= bus.scl_i;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= bus.sda_i;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            bitcnt       <= '0;
            shreg        <= '0;
            ptr_hi       <= '0;
            pcnt         <= 1'b0;
            ptr_done     <= 1'b0;
            phase        <= 1'b0;
            rw           <= 1'b0;
            ptr          <= '0;
            bus.sda_oe   <= 1'b0;
            bus.bus_busy <= 1'b0;
            bus.wr_strobe <= 1'b0;
        end else begin
            bus.wr_strobe <= 1'b0;
            if (start_det) begin
                state        <= ADDR;
                bitcnt       <= '0;
                phase        <= 1'b0;
                bus.sda_oe   <= 1'b0;
                bus.bus_busy <= 1'b1;
            end else if (stop_det) begin
                state        <= IDLE;
                bitcnt       <= '0;
                bus.sda_oe   <= 1'b0;
                bus.bus_busy <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shreg  <= rx_byte;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            if (rx_byte[7:1] == id) begin
                                rw    <= rx_byte[0];
                                phase <= 1'b0;
                                state <= ADDR_ACK;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    // phase 0: first fall asserts ACK; phase 1: next fall ends the ACK clock
                    ADDR_ACK: if (scl_fall) begin
                        if (!phase) begin
                            bus.sda_oe <= 1'b1;
                            phase      <= 1'b1;
                        end else if (rw) begin
                            shreg      <= {rd_byte[6:0], 1'b0};
                            bus.sda_oe <= ~rd_byte[7];
                            bitcnt     <= '0;
                            state      <= RDATA;
                        end else begin
                            bus.sda_oe <= 1'b0;
                            bitcnt     <= '0;
                            pcnt       <= 1'b0;
                            ptr_done   <= 1'b0;
                            state      <= PTR;
                        end
                    end
                    PTR: if (scl_rise) begin
                        shreg  <= rx_byte;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            if (pcnt == LAST_PB) begin
                                ptr      <= ptr_new;
                                ptr_done <= 1'b1;
                            end else begin
                                ptr_hi <= rx_byte;
                            end
                            pcnt  <= 1'b1;
                            phase <= 1'b0;
                            state <= PTR_ACK;
                        end
                    end
                    PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!phase) begin
                            bus.sda_oe <= 1'b1;
                            phase      <= 1'b1;
                        end else begin
                            bus.sda_oe <= 1'b0;
                            bitcnt     <= '0;
                            state      <= (state == WDATA_ACK || ptr_done) ? WDATA : PTR;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        shreg  <= rx_byte;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            bus.wr_strobe <= ~wp;
                            ptr           <= ptr + 1'b1;
                            phase         <= 1'b0;
                            state         <= WDATA_ACK;
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            bus.sda_oe <= ~shreg[7];
                            shreg      <= {shreg[6:0], 1'b0};
                        end else if (scl_rise) begin
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                ptr   <= ptr + 1'b1;
                                phase <= 1'b0;
                                state <= RDATA_ACK;
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_fall && !phase) begin
                            bus.sda_oe <= 1'b0;
                            phase      <= 1'b1;
                        end else if (scl_rise && phase) begin
                            if (sda_s2) begin
                                state <= IGNORE;
                            end else begin
                                shreg  <= rd_byte;
                                bitcnt <= '0;
                                state  <= RDATA;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr] <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.host_rdata <= '0;
        end else begin
            bus.host_rdata <= mem[bus.host_addr];
        end
    end
endmodule
